// File: rtl/mult4x4_if.sv
// Handshake and partial-product bus between the requester, the sequencer and the 4x2 stage.
interface mult4x4_if #(
    parameter int unsigned A_W    = 4,
    parameter int unsigned DIGITS = 2
);
    localparam int unsigned MB_W = 2 * DIGITS;
    localparam int unsigned P_W  = A_W + MB_W;

    logic              start;
    logic [A_W-1:0]    mult_a;
    logic [MB_W-1:0]   mult_b;
    logic              ready;
    logic [A_W-1:0]    part_out1;
    logic [1:0]        part_out2;
    logic [A_W+1:0]    part_in;
    logic [P_W-1:0]    product;
    logic              done;

    // Requester side; also closes the loop through the 4x2 stage.
    modport master (
        output start, mult_a, mult_b, part_in,
        input  ready, part_out1, part_out2, product, done
    );

    // Sequencer side.
    modport slave (
        input  start, mult_a, mult_b, part_in,
        output ready, part_out1, part_out2, product, done
    );
endinterface

// File: rtl/mult4x4_sequencer.sv
// Sequencer/accumulator for a combinational 4x2 partial-product multiplier:
// feeds one 2-bit multiplier digit per cycle, LSB digit first, and shift-adds
// the returned partial products into an unsigned full product.
module mult4x4_sequencer #(
    parameter int unsigned A_W    = 4,
    parameter int unsigned DIGITS = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mult4x4_if.slave     bus
);
    localparam int unsigned MB_W  = 2 * DIGITS;
    localparam int unsigned P_W   = A_W + MB_W;
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STEP,
        ST_FINISH
    } state_e;

    state_e            state_q;
    logic              ready_q;
    logic              done_q;
    logic [P_W-1:0]    product_q;
    logic [P_W-1:0]    acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [MB_W-1:0]   b_q;
    logic [A_W-1:0]    part_out1_q;
    logic [1:0]        part_out2_q;

    logic [CNT_W-1:0]  next_cnt_c;
    logic [1:0]        next_digit_c;
    logic [P_W-1:0]    acc_sum_c;

    // Next digit to present and the accumulator value after adding this cycle's partial product.
    always_comb begin
        next_cnt_c   = cnt_q + CNT_W'(1);
        next_digit_c = 2'(b_q >> {next_cnt_c, 1'b0});
        acc_sum_c    = acc_q + (P_W'(bus.part_in) << {cnt_q, 1'b0});
    end

    // Control FSM; the multiplicand is held in part_out1_q for the whole STEP phase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            product_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            b_q         <= '0;
            part_out1_q <= '0;
            part_out2_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        b_q         <= bus.mult_b;
                        part_out1_q <= bus.mult_a;
                        part_out2_q <= bus.mult_b[1:0];
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        ready_q     <= 1'b0;
                        state_q     <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    acc_q <= acc_sum_c;
                    cnt_q <= next_cnt_c;
                    if (cnt_q == CNT_W'(DIGITS - 1)) begin
                        product_q   <= acc_sum_c;
                        done_q      <= 1'b1;
                        part_out1_q <= '0;
                        part_out2_q <= '0;
                        state_q     <= ST_FINISH;
                    end else begin
                        part_out2_q <= next_digit_c;
                    end
                end
                ST_FINISH: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q     <= 1'b1;
                    part_out1_q <= '0;
                    part_out2_q <= '0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.product   = product_q;
    assign bus.part_out1 = part_out1_q;
    assign bus.part_out2 = part_out2_q;
endmodule

// File: tb/tb_mult4x4_sequencer.sv
// Directed bench for mult4x4_sequencer; the 4x2 stage is modelled as a combinational multiply.
module tb_mult4x4_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;
    int   done_cyc;

    mult4x4_if #(.A_W(4), .DIGITS(2)) bus ();

    mult4x4_sequencer #(.A_W(4), .DIGITS(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // 4x2 partial-product stage model.
    assign bus.part_in = 6'(bus.part_out1 * bus.part_out2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] d0;
        logic [1:0] d1;
        logic [7:0] prod;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Starts one operation from an IDLE cycle and checks every cycle up to the following IDLE cycle.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] d0, input logic [1:0] d1, input logic [7:0] prod);
        bus.start  = 1'b1;
        bus.mult_a = a;
        bus.mult_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        check("step0_ready", 32'(bus.ready), 0);
        check("step0_done", 32'(bus.done), 0);
        check("step0_pout1", 32'(bus.part_out1), 32'(a));
        check("step0_pout2", 32'(bus.part_out2), 32'(d0));
        @(negedge clk);
        check("step1_done", 32'(bus.done), 0);
        check("step1_pout1", 32'(bus.part_out1), 32'(a));
        check("step1_pout2", 32'(bus.part_out2), 32'(d1));
        @(negedge clk);
        done_cyc = cyc;
        check("fin_done", 32'(bus.done), 1);
        check("fin_ready", 32'(bus.ready), 0);
        check("fin_product", 32'(bus.product), 32'(prod));
        @(negedge clk);
        check("idle_done", 32'(bus.done), 0);
        check("idle_ready", 32'(bus.ready), 1);
        check("idle_product", 32'(bus.product), 32'(prod));
        check("idle_pout1", 32'(bus.part_out1), 0);
        check("idle_pout2", 32'(bus.part_out2), 0);
    endtask

    initial begin
        int first_done;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        done_cyc = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.mult_a = '0;
        bus.mult_b = '0;

        vecs[0] = '{a: 4'd15, b: 4'd15, d0: 2'd3, d1: 2'd3, prod: 8'd225};
        vecs[1] = '{a: 4'd9,  b: 4'd6,  d0: 2'd2, d1: 2'd1, prod: 8'd54};
        vecs[2] = '{a: 4'd0,  b: 4'd13, d0: 2'd1, d1: 2'd3, prod: 8'd0};
        vecs[3] = '{a: 4'd7,  b: 4'd5,  d0: 2'd1, d1: 2'd1, prod: 8'd35};
        vecs[4] = '{a: 4'd12, b: 4'd10, d0: 2'd2, d1: 2'd2, prod: 8'd120};
        vecs[5] = '{a: 4'd2,  b: 4'd14, d0: 2'd2, d1: 2'd3, prod: 8'd28};
        vecs[6] = '{a: 4'd1,  b: 4'd1,  d0: 2'd1, d1: 2'd0, prod: 8'd1};
        vecs[7] = '{a: 4'd15, b: 4'd0,  d0: 2'd0, d1: 2'd0, prod: 8'd0};

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state held over idle cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_ready", 32'(bus.ready), 1);
            check("rst_done", 32'(bus.done), 0);
            check("rst_product", 32'(bus.product), 0);
            check("rst_pout1", 32'(bus.part_out1), 0);
            check("rst_pout2", 32'(bus.part_out2), 0);
        end

        // Table of operations, one idle cycle between each.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].d0, vecs[i].d1, vecs[i].prod);
            @(negedge clk);
            check("gap_product", 32'(bus.product), 32'(vecs[i].prod));
        end

        // Start pulse and operand changes while busy are ignored.
        bus.start  = 1'b1;
        bus.mult_a = 4'd7;
        bus.mult_b = 4'd5;
        @(negedge clk);
        bus.mult_a = 4'd1;
        bus.mult_b = 4'd1;
        check("busy_pout1", 32'(bus.part_out1), 7);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_pout2", 32'(bus.part_out2), 1);
        check("busy_pout1b", 32'(bus.part_out1), 7);
        @(negedge clk);
        check("busy_done", 32'(bus.done), 1);
        check("busy_product", 32'(bus.product), 35);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_noreq_ready", 32'(bus.ready), 1);
            check("busy_noreq_done", 32'(bus.done), 0);
        end

        // Reset during the first STEP cycle aborts without a Done pulse.
        bus.start  = 1'b1;
        bus.mult_a = 4'd12;
        bus.mult_b = 4'd10;
        @(negedge clk);
        bus.start = 1'b0;
        check("abort_in_step", 32'(bus.ready), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(bus.ready), 1);
        check("abort_product", 32'(bus.product), 0);
        check("abort_pout1", 32'(bus.part_out1), 0);
        check("abort_pout2", 32'(bus.part_out2), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 0);
            check("abort_idle_ready", 32'(bus.ready), 1);
        end

        // Back-to-back: second Start in the first IDLE cycle after FINISH.
        run_op(4'd3, 4'd3, 2'd3, 2'd0, 8'd9);
        first_done = done_cyc;
        run_op(4'd2, 4'd14, 2'd2, 2'd3, 8'd28);
        check("b2b_done_spacing", 32'(done_cyc - first_done), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
